// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the unified memory port between core and debug requesters
// Optional round-robin arbitration: define MEM_ARB_ROUND_ROBIN_EN (default build is fixed core priority).
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_wdata_i,
    output logic              core_gnt_o,
    output logic              core_rvalid_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_gnt_o,
    output logic              dbg_rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic              owner_o
);

    generate
        if ((RD_LAT < 1) || (RD_LAT > 15)) begin : g_bad_rd_lat
            $error("mem_port_arbiter: RD_LAT must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] LAT_CNT = 4'(RD_LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              pick_dbg;

    // pick_dbg is only meaningful when at least one requester is asking.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign pick_dbg = dbg_req_i && (!core_req_i || !last_q);
`else
    assign pick_dbg = dbg_req_i && !core_req_i;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (core_req_i || dbg_req_i) begin
                    owner_d = pick_dbg;
                    last_d  = pick_dbg;
                    we_d    = pick_dbg ? dbg_we_i    : core_we_i;
                    addr_d  = pick_dbg ? dbg_addr_i  : core_addr_i;
                    wdata_d = pick_dbg ? dbg_wdata_i : core_wdata_i;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = LAT_CNT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rdata_d = mem_rdata_i;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All outputs decode registered state only; no path from the request inputs.
    assign mem_en_o      = (state_q == ISSUE);
    assign mem_we_o      = (state_q == ISSUE) && we_q;
    assign mem_addr_o    = addr_q;
    assign mem_wdata_o   = wdata_q;
    assign core_gnt_o    = (state_q == ISSUE) && !owner_q;
    assign dbg_gnt_o     = (state_q == ISSUE) && owner_q;
    assign core_rvalid_o = (state_q == RESP) && !owner_q;
    assign dbg_rvalid_o  = (state_q == RESP) && owner_q;
    assign rdata_o       = rdata_q;
    assign busy_o        = (state_q != IDLE);
    assign owner_o       = owner_q;

endmodule
